// File: rtl/trace_buffer.sv
// ---------------------------------------------------------------------------
// trace_buffer
//   Post-trigger CPU trace capture. An arm pulse starts a capture into a
//   DEPTH-entry circular store. The trigger fires when pc matches trig_pc,
//   and capture continues for POST_TRIG more qualifying cycles before it
//   freezes in DONE. Entries can be read in any state, using logical
//   addresses where 0 is the oldest stored entry.
//
// Ports
//   clk        in   clock; all state changes on its rising edge
//   reset      in   asynchronous, active-low reset
//   arm        in   one-cycle pulse that starts or restarts a capture
//   pc         in   PC of the current instruction
//   memwrite   in   data-memory write strobe
//   dataadr    in   data address
//   writedata  in   store data
//   trig_pc    in   PC value that fires the trigger
//   rd_en      in   read request strobe
//   rd_addr    in   logical read index (0 = oldest stored entry)
//   rd_data    out  registered entry {memwrite, pc, dataadr, writedata}
//   rd_valid   out  one-cycle pulse marking rd_data valid
//   state      out  FSM state: IDLE=00, ARMED=01, POST=10, DONE=11
//   count      out  number of stored entries, saturating at DEPTH
//   wrapped    out  sticky: at least one entry was overwritten
//
// Read handshake: rd_en is a request with no back-pressure. Each cycle with
// rd_en=1 produces exactly one rd_valid=1 pulse on the following cycle, and
// rd_data holds the answer from that cycle until the next read. An address
// at or beyond count returns all zeros.
// ---------------------------------------------------------------------------
module trace_buffer #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int FILTER_MW = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = 3*WIDTH+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [WIDTH-1:0] pc,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] trig_pc,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [EW-1:0]    rd_data,
  output logic             rd_valid,
  output logic [1:0]       state,
  output logic [AW:0]      count,
  output logic             wrapped
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    POST  = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [AW:0] POST_LIM  = (AW+1)'(POST_TRIG);

  state_e          state_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW:0]     count_q;
  logic            wrapped_q;
  logic [AW-1:0]   post_cnt_q;
  logic [EW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic [EW-1:0]   mem_q [DEPTH];

  logic            qual;
  logic            trig_hit;
  logic            wr_en;
  logic [EW-1:0]   wr_entry;
  logic [AW:0]     post_nxt;
  logic [AW-1:0]   rd_phys;
  logic            rd_hit;
  logic [EW-1:0]   rd_word;

  assign qual     = (FILTER_MW == 0) || memwrite;
  assign trig_hit = (state_q == ARMED) && (pc == trig_pc);

  // The trigger cycle is always captured even if it does not qualify;
  // arm suppresses any capture in its own cycle.
  assign wr_en = !arm &&
                 (((state_q == ARMED) && (qual || trig_hit)) ||
                  ((state_q == POST)  && qual));

  assign wr_entry = {memwrite, pc, dataadr, writedata};
  assign post_nxt = {1'b0, post_cnt_q} + 1'b1;

  // Oldest entry sits count slots behind the write pointer; with a full
  // buffer the low AW bits of count are zero so the oldest is at wr_ptr.
  // Uses the pre-write pointer and count, so a same-cycle capture does not
  // disturb the read.
  assign rd_phys = wr_ptr_q - count_q[AW-1:0] + rd_addr;
  assign rd_hit  = ({1'b0, rd_addr} < count_q);
  assign rd_word = rd_hit ? mem_q[rd_phys] : '0;

  // Entry storage, no reset needed on contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Control FSM plus capture bookkeeping and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      post_cnt_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_word;
      end

      if (arm) begin
        // Restart from any state; beats both trigger and capture.
        state_q    <= ARMED;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        wrapped_q  <= 1'b0;
        post_cnt_q <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (count_q == DEPTH_LIM) begin
            wrapped_q <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end

        case (state_q)
          ARMED: begin
            if (trig_hit) begin
              state_q    <= (POST_TRIG == 0) ? DONE : POST;
              post_cnt_q <= '0;
            end
          end
          POST: begin
            if (qual) begin
              post_cnt_q <= post_nxt[AW-1:0];
              if (post_nxt == POST_LIM) begin
                state_q <= DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state    = state_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_trace_buffer
//   Three instances share one stimulus stream:
//     u_def : POST_TRIG=8, FILTER_MW=0
//     u_flt : POST_TRIG=2, FILTER_MW=1
//     u_pt0 : POST_TRIG=0, FILTER_MW=0
//   The reference model keeps, per instance, the full list of captures since
//   the last arm. The stored contents are the last min(n, DEPTH) captures,
//   and wrapped means more than DEPTH captures were made.
// ---------------------------------------------------------------------------
module tb_trace_buffer;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int EW = 3*W+1;
  localparam int HN = 1024;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT inputs ----------------
  logic          arm;
  logic [W-1:0]  pc;
  logic          memwrite;
  logic [W-1:0]  dataadr;
  logic [W-1:0]  writedata;
  logic [W-1:0]  trig_pc;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  // ---------------- DUT outputs ----------------
  logic [EW-1:0] rdd0, rdd1, rdd2;
  logic          rdv0, rdv1, rdv2;
  logic [1:0]    st0, st1, st2;
  logic [AW:0]   cnt0, cnt1, cnt2;
  logic          wr0, wr1, wr2;

  trace_buffer #(.WIDTH(W), .DEPTH(D), .POST_TRIG(8), .FILTER_MW(0)) u_def (
    .clk(clk), .reset(reset), .arm(arm), .pc(pc), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .trig_pc(trig_pc),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd0), .rd_valid(rdv0),
    .state(st0), .count(cnt0), .wrapped(wr0));

  trace_buffer #(.WIDTH(W), .DEPTH(D), .POST_TRIG(2), .FILTER_MW(1)) u_flt (
    .clk(clk), .reset(reset), .arm(arm), .pc(pc), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .trig_pc(trig_pc),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd1), .rd_valid(rdv1),
    .state(st1), .count(cnt1), .wrapped(wr1));

  trace_buffer #(.WIDTH(W), .DEPTH(D), .POST_TRIG(0), .FILTER_MW(0)) u_pt0 (
    .clk(clk), .reset(reset), .arm(arm), .pc(pc), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .trig_pc(trig_pc),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd2), .rd_valid(rdv2),
    .state(st2), .count(cnt2), .wrapped(wr2));

  logic [EW-1:0] got_rdd [3];
  logic          got_rdv [3];
  logic [1:0]    got_st  [3];
  logic [AW:0]   got_cnt [3];
  logic          got_wr  [3];
  assign got_rdd[0] = rdd0;  assign got_rdd[1] = rdd1;  assign got_rdd[2] = rdd2;
  assign got_rdv[0] = rdv0;  assign got_rdv[1] = rdv1;  assign got_rdv[2] = rdv2;
  assign got_st[0]  = st0;   assign got_st[1]  = st1;   assign got_st[2]  = st2;
  assign got_cnt[0] = cnt0;  assign got_cnt[1] = cnt1;  assign got_cnt[2] = cnt2;
  assign got_wr[0]  = wr0;   assign got_wr[1]  = wr1;   assign got_wr[2]  = wr2;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // model state values: 0 idle, 1 armed, 2 post-trigger, 3 done
  int            pt [3];
  int            fm [3];
  int            ms [3];
  int            n  [3];
  int            pcnt [3];
  logic [EW-1:0] hist [3][HN];
  logic [EW-1:0] last_rdd [3];
  logic          exp_rdv;

  function automatic int m_count(input int i);
    return (n[i] > D) ? D : n[i];
  endfunction

  function automatic logic [EW-1:0] m_read(input int i, input int a);
    int c;
    c = m_count(i);
    if (a >= c) return '0;
    return hist[i][(n[i] - c + a) % HN];
  endfunction

  task automatic m_push(input int i, input logic [EW-1:0] e);
    hist[i][n[i] % HN] = e;
    n[i]++;
  endtask

  task automatic m_step(input int i);
    bit qual;
    logic [EW-1:0] e;
    qual = (fm[i] == 0) || memwrite;
    e    = {memwrite, pc, dataadr, writedata};
    if (arm) begin
      ms[i] = 1; n[i] = 0; pcnt[i] = 0;
    end else if (ms[i] == 1) begin
      if (pc == trig_pc) begin
        m_push(i, e);
        if (pt[i] == 0) ms[i] = 3;
        else begin ms[i] = 2; pcnt[i] = 0; end
      end else if (qual) begin
        m_push(i, e);
      end
    end else if (ms[i] == 2) begin
      if (qual) begin
        m_push(i, e);
        pcnt[i]++;
        if (pcnt[i] == pt[i]) ms[i] = 3;
      end
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      ms[i] = 0; n[i] = 0; pcnt[i] = 0; last_rdd[i] = '0;
    end
    exp_rdv = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d state", i), 128'(got_st[i]), 128'(ms[i]));
      check_eq($sformatf("u%0d count", i), 128'(got_cnt[i]), 128'(m_count(i)));
      check_eq($sformatf("u%0d wrapped", i), 128'(got_wr[i]), 128'(n[i] > D));
      check_eq($sformatf("u%0d rd_valid", i), 128'(got_rdv[i]), 128'(exp_rdv));
      check_eq($sformatf("u%0d rd_data", i), 128'(got_rdd[i]), 128'(last_rdd[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    arm = 1'b0; pc = 32'hFFFF_0000; memwrite = 1'b0;
    dataadr = '0; writedata = '0; rd_en = 1'b0; rd_addr = '0;
  endtask

  // Inputs are stable when called; model advances, edge occurs, outputs
  // are sampled 1 time unit later.
  task automatic cycle();
    if (rd_en) begin
      for (int i = 0; i < 3; i++) exp_q.push_back(m_read(i, int'(rd_addr)));
    end
    exp_rdv = rd_en;
    for (int i = 0; i < 3; i++) m_step(i);
    @(posedge clk);
    #1;
    if (exp_rdv) begin
      if (exp_q.size() >= 3) begin
        for (int i = 0; i < 3; i++) last_rdd[i] = exp_q.pop_front();
      end else begin
        check_eq("scoreboard depth", 128'(exp_q.size()), 128'(3));
      end
    end
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pt[0] = 8; pt[1] = 2; pt[2] = 0;
    fm[0] = 0; fm[1] = 1; fm[2] = 0;
    set_idle();
    trig_pc = 32'h20;
    reset = 1'b0;
    m_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Idle: no captures without arm, even on a trigger match
    pc = 32'h20; cycle();
    check_eq("idle no capture", 128'(cnt0), 128'(0));

    // A: pc stepping, trigger at 9th capture, DONE after 8 more
    arm = 1'b1; pc = 32'h20; cycle();
    arm = 1'b0;
    check_eq("A armed", 128'(st0), 128'(1));
    for (int k = 0; k <= 16; k++) begin
      pc = 32'(4*k); dataadr = 32'(k); writedata = 32'(3*k);
      cycle();
      if (k == 8) check_eq("A trigger to post", 128'(st0), 128'(2));
    end
    check_eq("A done", 128'(st0), 128'(3));
    check_eq("A count", 128'(cnt0), 128'(16));
    check_eq("A wrapped", 128'(wr0), 128'(1));
    pc = 32'h1000; rd_en = 1'b1; rd_addr = '0; cycle();
    rd_en = 1'b0;
    check_eq("A rd_valid", 128'(rdv0), 128'(1));
    check_eq("A oldest pc", 128'(rdd0[95:64]), 128'(32'h4));

    // B: filtered capture of three stores then trigger
    set_idle(); trig_pc = 32'h200;
    arm = 1'b1; cycle(); arm = 1'b0;
    for (int j = 0; j < 3; j++) begin
      memwrite = 1'b1; pc = 32'(32'h100 + 4*j); dataadr = 32'(4*j);
      writedata = (j == 0) ? 32'd999 : 32'(j);
      cycle();
    end
    memwrite = 1'b0; pc = 32'h200; dataadr = '0; writedata = '0; cycle();
    check_eq("B count", 128'(cnt1), 128'(4));
    check_eq("B post", 128'(st1), 128'(2));
    pc = 32'h300;
    for (int j = 0; j < 4; j++) begin
      rd_en = 1'b1; rd_addr = 4'(j); cycle();
      if (j < 3) begin
        check_eq($sformatf("B dataadr %0d", j), 128'(rdd1[63:32]), 128'(4*j));
        check_eq($sformatf("B writedata %0d", j), 128'(rdd1[31:0]),
                 (j == 0) ? 128'(999) : 128'(j));
        check_eq($sformatf("B memwrite %0d", j), 128'(rdd1[96]), 128'(1));
      end else begin
        check_eq("B trig memwrite", 128'(rdd1[96]), 128'(0));
        check_eq("B trig pc", 128'(rdd1[95:64]), 128'(32'h200));
      end
    end
    rd_en = 1'b0;

    // C: POST_TRIG=0, trigger on 3rd cycle after arm
    set_idle(); trig_pc = 32'h18;
    arm = 1'b1; cycle(); arm = 1'b0;
    pc = 32'h10; cycle();
    pc = 32'h14; cycle();
    check_eq("C still armed", 128'(st2), 128'(1));
    pc = 32'h18; cycle();
    check_eq("C done", 128'(st2), 128'(3));
    check_eq("C count", 128'(cnt2), 128'(3));
    check_eq("C wrapped", 128'(wr2), 128'(0));

    // D: re-arm in POST with count=5, colliding with a trigger match
    set_idle(); trig_pc = 32'h40;
    arm = 1'b1; cycle(); arm = 1'b0;
    pc = 32'h40; cycle();
    for (int j = 1; j <= 4; j++) begin pc = 32'(32'h40 + 4*j); cycle(); end
    check_eq("D post", 128'(st0), 128'(2));
    check_eq("D count", 128'(cnt0), 128'(5));
    arm = 1'b1; pc = 32'h40; cycle(); arm = 1'b0;
    check_eq("D rearm state", 128'(st0), 128'(1));
    check_eq("D rearm count", 128'(cnt0), 128'(0));

    // E: out-of-range read, then async reset in POST
    for (int j = 0; j < 4; j++) begin pc = 32'(32'h50 + 4*j); cycle(); end
    check_eq("E count", 128'(cnt0), 128'(4));
    rd_en = 1'b1; rd_addr = 4'd7; pc = 32'h60; cycle();
    rd_en = 1'b0;
    check_eq("E oor valid", 128'(rdv0), 128'(1));
    check_eq("E oor data", 128'(rdd0), 128'(0));
    pc = 32'h40; cycle();
    check_eq("E post", 128'(st0), 128'(2));
    #2;
    reset = 1'b0;
    #1;
    check_eq("E async state", 128'(st0), 128'(0));
    check_eq("E async count", 128'(cnt0), 128'(0));
    m_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    set_idle();

    // Random phase
    trig_pc = 32'h40;
    arm = 1'b1; cycle();
    for (int k = 0; k < 600; k++) begin
      arm       = ($urandom_range(0, 24) == 0);
      pc        = 32'($urandom_range(0, 31) * 4);
      memwrite  = 1'($urandom_range(0, 1));
      dataadr   = $urandom;
      writedata = $urandom;
      rd_en     = 1'($urandom_range(0, 1));
      rd_addr   = 4'($urandom_range(0, 15));
      cycle();
    end
    set_idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the width of the PC, address and data fields.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of entries; it must be a power of two, at least 2.
REQ-003 SHALL have parameter POST_TRIG, default 8, meaning the number of qualifying captures after the trigger entry (0..DEPTH-1).
REQ-004 SHALL have parameter FILTER_MW, default 0, meaning 0 = capture every cycle and 1 = capture only memwrite cycles.
REQ-005 SHALL have derived localparam AW = $clog2(DEPTH) and EW = 3*WIDTH+1 (entry width).
REQ-006 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  in  1  the asynchronous, active-low reset.
REQ-008 SHALL have port arm  in  1  a one-cycle pulse that starts or restarts a capture.
REQ-009 SHALL have port pc  in  WIDTH  the PC of the current instruction.
REQ-010 SHALL have port memwrite  in  1  the CPU data-memory write strobe.
REQ-011 SHALL have port dataadr  in  WIDTH  the CPU data address.
REQ-012 SHALL have port writedata  in  WIDTH  the CPU store data.
REQ-013 SHALL have port trig_pc  in  WIDTH  the PC value that fires the trigger.
REQ-014 SHALL have port rd_en  in  1  the read request strobe.
REQ-015 SHALL have port rd_addr  in  AW  the logical read index, where 0 = oldest stored entry.
REQ-016 SHALL have port rd_data  out  EW  the entry {memwrite, pc, dataadr, writedata}.
REQ-017 SHALL have port rd_valid  out  1  a one-cycle pulse marking rd_data valid.
REQ-018 SHALL have port state  out  2  the FSM state: IDLE=00, ARMED=01, POST=10, DONE=11.
REQ-019 SHALL have port count  out  AW+1  the number of stored entries, saturating at DEPTH.
REQ-020 SHALL have port wrapped  out  1  a sticky flag indicating that at least one entry was overwritten.

Function
REQ-021 SHALL define a qualifying cycle as (FILTER_MW==0) or (memwrite==1).
REQ-022 SHALL define the trigger condition as pc==trig_pc while in ARMED.
REQ-023 SHALL, on a write, store {memwrite, pc, dataadr, writedata} at wr_ptr, advance wr_ptr mod DEPTH, and increment count saturating at DEPTH.
REQ-024 SHALL set wrapped on a write made when count==DEPTH.
REQ-025 SHALL, in IDLE, perform no writes; arm moves to ARMED with wr_ptr=0, count=0, wrapped=0, and the trigger is ignored in that same cycle.
REQ-026 SHALL, in ARMED, write every qualifying cycle; the trigger writes the trigger cycle whether or not it qualifies and moves to POST with post_cnt=0.
REQ-027 SHALL, if POST_TRIG==0, go from ARMED straight to DONE on the trigger.
REQ-028 SHALL, in POST, write every qualifying cycle and increment post_cnt; the write that makes post_cnt==POST_TRIG moves to DONE.
REQ-029 SHALL ignore further trigger matches while in POST.
REQ-030 SHALL, in DONE, perform no writes and hold contents and count.
REQ-031 SHALL, on arm in ARMED, POST or DONE, clear wr_ptr, count, wrapped and post_cnt and enter ARMED with no write that cycle; arm has priority over the trigger and over the capture.
REQ-032 SHALL serve reads in any state: physical index = (wr_ptr - count + rd_addr) mod DEPTH.
REQ-033 SHALL register rd_data so that rd_valid=1 in the cycle after rd_en.
REQ-034 SHALL return rd_data=0 with rd_valid=1 when rd_addr >= count.
REQ-035 SHALL, on a read and a write in the same cycle, compute the read from the pre-write wr_ptr and count.
REQ-036 SHALL keep storage as registers or inferred RAM, with no reset required on entry contents.

Reset
REQ-037 SHALL, while reset==0, asynchronously force state=IDLE, count=0, wrapped=0, rd_valid=0, rd_data=0, and clear wr_ptr and post_cnt.
REQ-038 SHALL make a reset assertion mid-capture abort the capture, so that count reads 0 afterwards.
REQ-039 SHALL make its first state change on the first rising clk edge after reset deasserts.

Verification
REQ-040 SHALL cover: defaults; arm, then pc stepping 0x0,0x4,...; trig_pc=0x20 -> trigger at the 9th capture, DONE after 8 more captures; count=16 (17 writes), wrapped=1; rd_addr 0 returns pc=0x4.
REQ-041 SHALL cover: FILTER_MW=1; 3 memwrite cycles with dataadr 0x0/0x4/0x8 and writedata 999/1/2, then trigger -> rd_addr 0..2 return those, and the trigger entry has memwrite=0.
REQ-042 SHALL cover: POST_TRIG=0; trigger on the 3rd cycle after arm -> DONE next cycle, count=3, wrapped=0.
REQ-043 SHALL cover: arm pulsed in POST with count=5 -> state=ARMED, count=0, no write that cycle.
REQ-044 SHALL cover: rd_addr=7 while count=4 -> rd_data=0 with rd_valid=1 one cycle later; reset asserted during POST -> state=IDLE and count=0 immediately, without waiting for a clock edge.
